// File: rtl/instr_fetch_if.sv
// Fetch-to-controller instruction handshake.
// The fetch unit drives ir/ir_addr/ir_valid; the controller drives ir_ready.
interface instr_fetch_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_addr;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output ir,
    output ir_addr,
    output ir_valid,
    input  ir_ready
  );

  modport slave (
    input  ir,
    input  ir_addr,
    input  ir_valid,
    output ir_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: drives PC clear/up, waits out ROM latency,
// holds the fetched word in ir and offers it on a valid/ready handshake.
module instr_fetch #(
  parameter int          ADDR_W  = 7,
  parameter int          DATA_W  = 16,
  parameter int          ROM_LAT = 1,
  parameter logic [3:0]  HALT_OP = 4'h5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              pc_clear,
  output logic              pc_up,
  output logic              halted,
  output logic              wrapped,
  instr_fetch_if.master     fb
);

  localparam int S_IDLE = 0;
  localparam int S_CLR  = 1;
  localparam int S_WAIT = 2;
  localparam int S_VAL  = 3;
  localparam int S_HALT = 4;

  localparam logic [4:0] IDLE   = 5'b00001;
  localparam logic [4:0] CLEAR  = 5'b00010;
  localparam logic [4:0] WAIT   = 5'b00100;
  localparam logic [4:0] VALID  = 5'b01000;
  localparam logic [4:0] HALTED = 5'b10000;

  // one-hot state, so every state-decoded output is a flop
  logic [4:0] state;
  logic [4:0] nxt;
  logic [2:0] cnt;
  logic       lat_hit;
  logic       accept;
  logic       is_halt;

  assign lat_hit = cnt == 3'(ROM_LAT);
  assign accept  = state[S_VAL] & fb.ir_ready;
  assign is_halt = fb.ir[DATA_W-1 -: 4] == HALT_OP;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      state[S_IDLE]: if (start) nxt = CLEAR;
      state[S_CLR]:  nxt = WAIT;
      state[S_WAIT]: if (lat_hit) nxt = VALID;
      state[S_VAL]: begin
        if (fb.ir_ready) nxt = is_halt ? HALTED : WAIT;
      end
      state[S_HALT]: if (start) nxt = CLEAR;
      default:       nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_clear    = state[S_CLR];
    pc_up       = accept;
    fb.ir_valid = state[S_VAL];
    halted      = state[S_HALT];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb.ir      <= '0;
      fb.ir_addr <= '0;
      wrapped    <= 1'b0;
      cnt        <= '0;
    end else begin
      if (state[S_CLR]) begin
        wrapped <= 1'b0;
        cnt     <= '0;
      end
      if (state[S_WAIT]) begin
        cnt <= cnt + 3'd1;
        if (lat_hit) begin
          fb.ir      <= rom_data;
          fb.ir_addr <= pc_address;
        end
      end
      if (accept) begin
        cnt <= '0;
        if (fb.ir_addr == '1) wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC/ROM models drive two builds,
// ROM_LAT=1 and ROM_LAT=3, sharing one ROM image.
module tb_instr_fetch;

  logic clk;
  logic reset_n;

  logic        start1, start2;
  logic        pc_clear1, pc_up1, halted1, wrapped1;
  logic        pc_clear2, pc_up2, halted2, wrapped2;
  logic [6:0]  pc1 = '0;
  logic [6:0]  pc2 = '0;
  logic [15:0] rom_data1 = '0;
  logic [15:0] d1 = '0;
  logic [15:0] d2 = '0;
  logic [15:0] rom_data2 = '0;
  logic [15:0] rom [128];

  int total  = 0;
  int passed = 0;
  int n_up;

  instr_fetch_if #(.ADDR_W(7), .DATA_W(16)) fb1 ();
  instr_fetch_if #(.ADDR_W(7), .DATA_W(16)) fb2 ();

  instr_fetch #(.ADDR_W(7), .DATA_W(16), .ROM_LAT(1), .HALT_OP(4'h5)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start1),
    .pc_address (pc1),
    .rom_data   (rom_data1),
    .pc_clear   (pc_clear1),
    .pc_up      (pc_up1),
    .halted     (halted1),
    .wrapped    (wrapped1),
    .fb         (fb1)
  );

  instr_fetch #(.ADDR_W(7), .DATA_W(16), .ROM_LAT(3), .HALT_OP(4'h5)) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start2),
    .pc_address (pc2),
    .rom_data   (rom_data2),
    .pc_clear   (pc_clear2),
    .pc_up      (pc_up2),
    .halted     (halted2),
    .wrapped    (wrapped2),
    .fb         (fb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC counters (not reset by reset_n) and synchronous ROMs
  always @(posedge clk) begin
    if (pc_clear1)   pc1 <= '0;
    else if (pc_up1) pc1 <= pc1 + 7'd1;
    rom_data1 <= rom[pc1];
  end

  always @(posedge clk) begin
    if (pc_clear2)   pc2 <= '0;
    else if (pc_up2) pc2 <= pc2 + 7'd1;
    d1        <= rom[pc2];
    d2        <= d1;
    rom_data2 <= d2;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic ev;
    reset_n = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    fb1.ir_ready = 1'b0;
    fb2.ir_ready = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h2000 + 16'(i);
    rom[0] = 16'h1234;
    rom[2] = 16'h5000;
    tick(2);
    chk("rst_valid", fb1.ir_valid, 0);
    chk("rst_ir", fb1.ir, 0);
    chk("rst_addr", fb1.ir_addr, 0);
    chk("rst_halted", halted1, 0);
    chk("rst_wrapped", wrapped1, 0);
    chk("rst_clear", pc_clear1, 0);
    chk("rst_up", pc_up1, 0);
    reset_n = 1'b1;
    tick(1);

    // first fetch with controller stalled
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    chk("clr_e0", pc_clear1, 1);
    chk("v_e0", fb1.ir_valid, 0);
    tick(1);
    chk("clr_e1", pc_clear1, 0);
    chk("v_e1", fb1.ir_valid, 0);
    tick(1);
    chk("v_e2", fb1.ir_valid, 0);
    tick(1);
    chk("v_e3", fb1.ir_valid, 1);
    chk("ir_e3", fb1.ir, 16'h1234);
    chk("addr_e3", fb1.ir_addr, 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("stall_ir", fb1.ir, 16'h1234);
      chk("stall_v", fb1.ir_valid, 1);
      chk("stall_up", pc_up1, 0);
    end

    // run into HALT at address 2
    fb1.ir_ready = 1'b1;
    #1;
    chk("up_comb", pc_up1, 1);
    n_up = 1;
    for (int i = 0; i < 40 && !halted1; i++) begin
      tick(1);
      if (pc_up1) n_up++;
    end
    chk("halted", halted1, 1);
    chk("halt_ups", n_up, 3);
    chk("halt_addr", fb1.ir_addr, 2);
    chk("halt_ir", fb1.ir, 16'h5000);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("hold_v", fb1.ir_valid, 0);
      chk("hold_up", pc_up1, 0);
      chk("hold_h", halted1, 1);
    end

    // restart, streaming with ready held high
    for (int i = 0; i < 4; i++) rom[i] = 16'h1000 + 16'(i);
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    chk("restart_h", halted1, 0);
    chk("restart_clr", pc_clear1, 1);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      ev = (k >= 3) && (k % 3 == 0);
      chk("str_v", fb1.ir_valid, 32'(ev));
      chk("str_up", pc_up1, 32'(ev));
      if (ev) begin
        chk("str_addr", fb1.ir_addr, k / 3 - 1);
        chk("str_ir", fb1.ir, 16'h1000 + 16'(k / 3 - 1));
      end
    end

    // wrap past address 127
    for (int i = 0; i < 600 && !(fb1.ir_valid && fb1.ir_addr == 7'd127); i++)
      tick(1);
    chk("reach127", fb1.ir_addr, 127);
    chk("d127", fb1.ir, 16'h207f);
    chk("w_pre", wrapped1, 0);
    tick(1);
    chk("wrap_set", wrapped1, 1);
    for (int i = 0; i < 10 && !fb1.ir_valid; i++) tick(1);
    chk("wrap_v", fb1.ir_valid, 1);
    chk("wrap_addr", fb1.ir_addr, 0);
    chk("wrap_ir", fb1.ir, 16'h1000);
    fb1.ir_ready = 1'b0;
    rom[1] = 16'h5000;
    tick(2);
    chk("hold_addr", fb1.ir_addr, 0);
    fb1.ir_ready = 1'b1;
    for (int i = 0; i < 20 && !halted1; i++) tick(1);
    chk("halt2", halted1, 1);
    chk("wrap_keep", wrapped1, 1);
    rom[1] = 16'h1001;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(1);
    chk("wrap_clr", wrapped1, 0);

    // start ignored in VALID/WAIT, then reset mid-WAIT
    fb1.ir_ready = 1'b0;
    for (int i = 0; i < 10 && !fb1.ir_valid; i++) tick(1);
    chk("r_v0", fb1.ir_addr, 0);
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    chk("st_val_v", fb1.ir_valid, 1);
    chk("st_val_clr", pc_clear1, 0);
    fb1.ir_ready = 1'b1;
    tick(1);
    fb1.ir_ready = 1'b0;
    for (int i = 0; i < 10 && !fb1.ir_valid; i++) tick(1);
    chk("r_addr1", fb1.ir_addr, 1);
    chk("r_ir1", fb1.ir, 16'h1001);
    fb1.ir_ready = 1'b1;
    tick(1);
    fb1.ir_ready = 1'b0;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    chk("st_wait_clr", pc_clear1, 0);
    chk("st_wait_v", fb1.ir_valid, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_ir", fb1.ir, 0);
    chk("ar_addr", fb1.ir_addr, 0);
    chk("ar_v", fb1.ir_valid, 0);
    chk("ar_h", halted1, 0);
    chk("ar_w", wrapped1, 0);
    chk("ar_clr", pc_clear1, 0);
    chk("ar_up", pc_up1, 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("idle_v", fb1.ir_valid, 0);
    chk("idle_clr", pc_clear1, 0);

    // ROM_LAT=3 build
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    chk("l3_clr", pc_clear2, 1);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk("l3_sv", fb2.ir_valid, 32'(k == 5));
    end
    chk("l3_ir0", fb2.ir, 16'h1000);
    chk("l3_addr0", fb2.ir_addr, 0);
    fb2.ir_ready = 1'b1;
    for (int k = 6; k <= 10; k++) begin
      tick(1);
      chk("l3_av", fb2.ir_valid, 32'(k == 10));
    end
    chk("l3_ir1", fb2.ir, 16'h1001);
    chk("l3_addr1", fb2.ir_addr, 1);
    fb2.ir_ready = 1'b0;
    tick(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
